// File: rtl/alu_issue_if.sv
// Decode-to-execute issue bundle: decoded instruction offer, writeback bypass,
// flush, and the registered ALU operation handed to the execute stage.
interface alu_issue_if;
    localparam int DATA_W = 32;

    logic              dec_valid_in;
    logic              dec_ready_out;
    logic [6:0]        dec_opcode_in;
    logic [2:0]        dec_funct3_in;
    logic [6:0]        dec_funct7_in;
    logic [4:0]        dec_rs1_addr_in;
    logic [4:0]        dec_rs2_addr_in;
    logic [4:0]        dec_rd_in;
    logic [DATA_W-1:0] dec_rs1_data_in;
    logic [DATA_W-1:0] dec_rs2_data_in;
    logic [DATA_W-1:0] dec_imm_in;
    logic [DATA_W-1:0] dec_pc_in;

    logic              fwd_valid_in;
    logic [4:0]        fwd_rd_in;
    logic [DATA_W-1:0] fwd_data_in;

    logic              flush_in;
    logic              ex_ready_in;

    logic              ex_valid_out;
    logic [9:0]        alu_cid_out;
    logic [DATA_W-1:0] alu_arg1_out;
    logic [DATA_W-1:0] alu_arg2_out;
    logic [4:0]        ex_rd_out;
    logic              ex_illegal_out;

    // Master drives decode/bypass/control and consumes the issued operation.
    modport master (
        output dec_valid_in, dec_opcode_in, dec_funct3_in, dec_funct7_in,
        output dec_rs1_addr_in, dec_rs2_addr_in, dec_rd_in,
        output dec_rs1_data_in, dec_rs2_data_in, dec_imm_in, dec_pc_in,
        output fwd_valid_in, fwd_rd_in, fwd_data_in,
        output flush_in, ex_ready_in,
        input  dec_ready_out, ex_valid_out, alu_cid_out,
        input  alu_arg1_out, alu_arg2_out, ex_rd_out, ex_illegal_out
    );

    modport slave (
        input  dec_valid_in, dec_opcode_in, dec_funct3_in, dec_funct7_in,
        input  dec_rs1_addr_in, dec_rs2_addr_in, dec_rd_in,
        input  dec_rs1_data_in, dec_rs2_data_in, dec_imm_in, dec_pc_in,
        input  fwd_valid_in, fwd_rd_in, fwd_data_in,
        input  flush_in, ex_ready_in,
        output dec_ready_out, ex_valid_out, alu_cid_out,
        output alu_arg1_out, alu_arg2_out, ex_rd_out, ex_illegal_out
    );
endinterface

// File: rtl/alu_issue.sv
// Single-entry issue register between decode and the ALU: selects operands and
// the ALU operation code per opcode, applies the writeback bypass at capture.
module alu_issue #(
    parameter logic FWD_EN = 1'b1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    alu_issue_if.slave bus
);
    localparam int DATA_W = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [9:0]        CID_ADD = 10'b000_0000000;
    localparam logic [9:0]        CID_SUB = 10'b000_0100000;
    localparam logic [DATA_W-1:0] LINK_OFS = 32'd4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [9:0]        cid_q, cid_d;
    logic [DATA_W-1:0] arg1_q, arg1_d;
    logic [DATA_W-1:0] arg2_q, arg2_d;
    logic [4:0]        rd_q, rd_d;
    logic              illegal_q, illegal_d;

    logic              ready;
    logic              capture;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [9:0]        dec_cid;
    logic [DATA_W-1:0] dec_arg1;
    logic [DATA_W-1:0] dec_arg2;
    logic [4:0]        dec_rd;
    logic              dec_illegal;

    // x0 is hardwired zero, so a writeback to it must never be bypassed.
    function automatic logic [DATA_W-1:0] bypass(
        input logic [4:0]        addr,
        input logic [DATA_W-1:0] rf_data,
        input logic              fwd_valid,
        input logic [4:0]        fwd_rd,
        input logic [DATA_W-1:0] fwd_data
    );
        if (FWD_EN && fwd_valid && (fwd_rd == addr) && (addr != 5'd0)) begin
            return fwd_data;
        end
        return rf_data;
    endfunction

    assign rs1_val = bypass(bus.dec_rs1_addr_in, bus.dec_rs1_data_in,
                            bus.fwd_valid_in, bus.fwd_rd_in, bus.fwd_data_in);
    assign rs2_val = bypass(bus.dec_rs2_addr_in, bus.dec_rs2_data_in,
                            bus.fwd_valid_in, bus.fwd_rd_in, bus.fwd_data_in);

    always_comb begin
        dec_cid     = CID_ADD;
        dec_arg1    = '0;
        dec_arg2    = '0;
        dec_rd      = bus.dec_rd_in;
        dec_illegal = 1'b0;
        case (bus.dec_opcode_in)
            OPC_OP: begin
                dec_arg1 = rs1_val;
                dec_arg2 = rs2_val;
                dec_cid  = {bus.dec_funct3_in, bus.dec_funct7_in};
            end
            OPC_OP_IMM: begin
                dec_arg1 = rs1_val;
                dec_arg2 = bus.dec_imm_in;
                // Only the shift-right group uses funct7 to pick SRLI vs SRAI.
                if (bus.dec_funct3_in == 3'b101) begin
                    dec_cid = {bus.dec_funct3_in, bus.dec_funct7_in};
                end else begin
                    dec_cid = {bus.dec_funct3_in, 7'b0000000};
                end
            end
            OPC_LUI: begin
                dec_arg2 = bus.dec_imm_in;
            end
            OPC_AUIPC: begin
                dec_arg1 = bus.dec_pc_in;
                dec_arg2 = bus.dec_imm_in;
            end
            OPC_LOAD: begin
                dec_arg1 = rs1_val;
                dec_arg2 = bus.dec_imm_in;
            end
            OPC_STORE: begin
                dec_arg1 = rs1_val;
                dec_arg2 = bus.dec_imm_in;
                dec_rd   = 5'd0;
            end
            OPC_JAL, OPC_JALR: begin
                dec_arg1 = bus.dec_pc_in;
                dec_arg2 = LINK_OFS;
            end
            OPC_BRANCH: begin
                dec_arg1 = rs1_val;
                dec_arg2 = rs2_val;
                dec_cid  = CID_SUB;
                dec_rd   = 5'd0;
            end
            default: begin
                dec_illegal = 1'b1;
                dec_rd      = 5'd0;
            end
        endcase
    end

    // Reset term keeps the offer side open while the entry is being cleared.
    assign ready   = rst_in || (state_q == EMPTY) || bus.ex_ready_in;
    assign capture = bus.dec_valid_in && ready && !bus.flush_in;

    always_comb begin
        state_d   = state_q;
        cid_d     = cid_q;
        arg1_d    = arg1_q;
        arg2_d    = arg2_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;
        if (bus.flush_in) begin
            state_d = EMPTY;
        end else if (capture) begin
            state_d   = FULL;
            cid_d     = dec_cid;
            arg1_d    = dec_arg1;
            arg2_d    = dec_arg2;
            rd_d      = dec_rd;
            illegal_d = dec_illegal;
        end else if ((state_q == FULL) && bus.ex_ready_in) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= EMPTY;
            cid_q     <= '0;
            arg1_q    <= '0;
            arg2_q    <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cid_q     <= cid_d;
            arg1_q    <= arg1_d;
            arg2_q    <= arg2_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.dec_ready_out  = ready;
    assign bus.ex_valid_out   = (state_q == FULL);
    assign bus.alu_cid_out    = cid_q;
    assign bus.alu_arg1_out   = arg1_q;
    assign bus.alu_arg2_out   = arg2_q;
    assign bus.ex_rd_out      = rd_q;
    assign bus.ex_illegal_out = illegal_q;
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed instruction stream, a reference model of the
// issue entry checked every cycle, plus literal expectations per scenario.
module tb_alu_issue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;

    alu_issue_if bus();

    alu_issue #(.FWD_EN(1'b1)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [9:0]  cid;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [4:0]  rd;
        logic        ill;
    } entry_t;

    entry_t m;
    logic   m_zero = 1'b0;
    logic   m_started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] src(input logic [4:0] addr, input logic [31:0] rf);
        if (bus.fwd_valid_in && addr != 0 && bus.fwd_rd_in == addr) return bus.fwd_data_in;
        return rf;
    endfunction

    // What the instruction on the decode side should become once issued.
    function automatic entry_t expect_issue();
        entry_t e;
        logic [31:0] r1, r2;
        r1 = src(bus.dec_rs1_addr_in, bus.dec_rs1_data_in);
        r2 = src(bus.dec_rs2_addr_in, bus.dec_rs2_data_in);
        e = '0;
        e.valid = 1'b1;
        e.rd = bus.dec_rd_in;
        case (bus.dec_opcode_in)
            7'b0110011: begin e.a1 = r1; e.a2 = r2; e.cid = {bus.dec_funct3_in, bus.dec_funct7_in}; end
            7'b0010011: begin
                e.a1 = r1; e.a2 = bus.dec_imm_in;
                e.cid = (bus.dec_funct3_in == 3'd5) ? {bus.dec_funct3_in, bus.dec_funct7_in}
                                                    : {bus.dec_funct3_in, 7'd0};
            end
            7'b0110111: e.a2 = bus.dec_imm_in;
            7'b0010111: begin e.a1 = bus.dec_pc_in; e.a2 = bus.dec_imm_in; end
            7'b0000011: begin e.a1 = r1; e.a2 = bus.dec_imm_in; end
            7'b0100011: begin e.a1 = r1; e.a2 = bus.dec_imm_in; e.rd = 0; end
            7'b1101111, 7'b1100111: begin e.a1 = bus.dec_pc_in; e.a2 = 32'd4; end
            7'b1100011: begin e.a1 = r1; e.a2 = r2; e.cid = 10'h020; e.rd = 0; end
            default: begin e.ill = 1'b1; e.rd = 0; end
        endcase
        return e;
    endfunction

    always @(posedge clk) begin
        m_started <= 1'b1;
        if (rst) begin
            m <= '0;
            m_zero <= 1'b1;
        end else if (bus.flush_in) begin
            m.valid <= 1'b0;
            m_zero <= 1'b0;
        end else if (bus.dec_valid_in && (!m.valid || bus.ex_ready_in)) begin
            m <= expect_issue();
            m_zero <= 1'b0;
        end else if (m.valid && bus.ex_ready_in) begin
            m.valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("m_valid", 32'(bus.ex_valid_out), 32'(m.valid));
            chk("m_ready", 32'(bus.dec_ready_out), 32'(rst || !m.valid || bus.ex_ready_in));
            if (m.valid || m_zero) begin
                chk("m_cid", 32'(bus.alu_cid_out), 32'(m.cid));
                chk("m_arg1", bus.alu_arg1_out, m.a1);
                chk("m_arg2", bus.alu_arg2_out, m.a2);
                chk("m_rd", 32'(bus.ex_rd_out), 32'(m.rd));
                chk("m_ill", 32'(bus.ex_illegal_out), 32'(m.ill));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [31:0] pc);
        bus.dec_valid_in = 1'b1;
        bus.dec_opcode_in = op;
        bus.dec_funct3_in = f3;
        bus.dec_funct7_in = f7;
        bus.dec_rs1_addr_in = ra1;
        bus.dec_rs2_addr_in = ra2;
        bus.dec_rd_in = rd;
        bus.dec_rs1_data_in = d1;
        bus.dec_rs2_data_in = d2;
        bus.dec_imm_in = imm;
        bus.dec_pc_in = pc;
    endtask

    initial begin
        offer(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        bus.dec_valid_in = 1'b0;
        bus.fwd_valid_in = 1'b0;
        bus.fwd_rd_in = 5'd0;
        bus.fwd_data_in = 32'd0;
        bus.flush_in = 1'b0;
        bus.ex_ready_in = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(bus.ex_valid_out), 32'd0);
        chk("rst_arg1", bus.alu_arg1_out, 32'd0);
        chk("rst_ready", 32'(bus.dec_ready_out), 32'd1);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.dec_ready_out), 32'd1);

        // ADD x3,x1,x2
        bus.ex_ready_in = 1'b1;
        offer(7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 32'd0);
        tick();
        chk("add_valid", 32'(bus.ex_valid_out), 32'd1);
        chk("add_cid", 32'(bus.alu_cid_out), 32'd0);
        chk("add_arg1", bus.alu_arg1_out, 32'd5);
        chk("add_arg2", bus.alu_arg2_out, 32'd7);
        chk("add_rd", 32'(bus.ex_rd_out), 32'd3);

        // SRAI keeps funct7; ADDI drops it
        offer(7'b0010011, 3'b101, 7'b0100000, 5'd4, 5'd0, 5'd8, 32'h80, 32'd0, 32'd3, 32'd0);
        tick();
        chk("srai_cid", 32'(bus.alu_cid_out), 32'h2A0);
        chk("srai_arg2", bus.alu_arg2_out, 32'd3);
        offer(7'b0010011, 3'b000, 7'b0100000, 5'd1, 5'd0, 5'd2, 32'd5, 32'd0, 32'd9, 32'd0);
        tick();
        chk("addi_cid", 32'(bus.alu_cid_out), 32'd0);
        chk("addi_arg2", bus.alu_arg2_out, 32'd9);

        // Backpressure for three cycles with a SUB waiting
        bus.ex_ready_in = 1'b0;
        offer(7'b0110011, 3'd0, 7'b0100000, 5'd5, 5'd6, 5'd4, 32'd10, 32'd3, 32'd0, 32'd0);
        #1;
        chk("hold_ready", 32'(bus.dec_ready_out), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_arg2", bus.alu_arg2_out, 32'd9);
            chk("hold_valid", 32'(bus.ex_valid_out), 32'd1);
        end
        bus.ex_ready_in = 1'b1;
        #1;
        chk("release_ready", 32'(bus.dec_ready_out), 32'd1);
        tick();
        chk("sub_cid", 32'(bus.alu_cid_out), 32'h020);
        chk("sub_arg1", bus.alu_arg1_out, 32'd10);
        chk("sub_rd", 32'(bus.ex_rd_out), 32'd4);

        // Forwarding, no re-forward while held, and x0 never forwarded
        offer(7'b0110011, 3'd0, 7'd0, 5'd1, 5'd7, 5'd5, 32'd0, 32'd1, 32'd0, 32'd0);
        bus.fwd_valid_in = 1'b1;
        bus.fwd_rd_in = 5'd1;
        bus.fwd_data_in = 32'hDEAD;
        tick();
        chk("fwd_arg1", bus.alu_arg1_out, 32'hDEAD);
        chk("fwd_arg2", bus.alu_arg2_out, 32'd1);
        bus.ex_ready_in = 1'b0;
        bus.fwd_data_in = 32'hBEEF;
        tick();
        chk("fwd_held", bus.alu_arg1_out, 32'hDEAD);
        bus.ex_ready_in = 1'b1;
        bus.dec_rs1_addr_in = 5'd0;
        bus.fwd_rd_in = 5'd0;
        tick();
        chk("fwd_x0", bus.alu_arg1_out, 32'd0);
        offer(7'b0110011, 3'd0, 7'd0, 5'd3, 5'd7, 5'd5, 32'h11, 32'd0, 32'd0, 32'd0);
        bus.fwd_rd_in = 5'd7;
        bus.fwd_data_in = 32'h55;
        tick();
        chk("fwd_rs2", bus.alu_arg2_out, 32'h55);
        chk("fwd_rs2_a1", bus.alu_arg1_out, 32'h11);
        bus.fwd_valid_in = 1'b0;

        // Flush beats a simultaneous offer
        bus.flush_in = 1'b1;
        tick();
        chk("flush_valid", 32'(bus.ex_valid_out), 32'd0);
        bus.flush_in = 1'b0;

        offer(7'b1111111, 3'd0, 7'd0, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 32'd3, 32'd4);
        tick();
        chk("ill_flag", 32'(bus.ex_illegal_out), 32'd1);
        chk("ill_rd", 32'(bus.ex_rd_out), 32'd0);
        chk("ill_arg1", bus.alu_arg1_out, 32'd0);
        offer(7'b1100011, 3'd1, 7'd0, 5'd3, 5'd4, 5'd6, 32'd3, 32'd4, 32'd0, 32'd0);
        tick();
        chk("br_ill", 32'(bus.ex_illegal_out), 32'd0);
        chk("br_rd", 32'(bus.ex_rd_out), 32'd0);
        chk("br_cid", 32'(bus.alu_cid_out), 32'h020);
        offer(7'b0100011, 3'd2, 7'd0, 5'd8, 5'd9, 5'd7, 32'h1000, 32'd0, 32'd8, 32'd0);
        tick();
        chk("st_rd", 32'(bus.ex_rd_out), 32'd0);
        chk("st_arg1", bus.alu_arg1_out, 32'h1000);
        offer(7'b1101111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd0, 32'h200);
        tick();
        chk("jal_arg1", bus.alu_arg1_out, 32'h200);
        chk("jal_arg2", bus.alu_arg2_out, 32'd4);
        offer(7'b0110111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd2, 32'd5, 32'd0, 32'h12345000, 32'h40);
        tick();
        chk("lui_arg1", bus.alu_arg1_out, 32'd0);
        chk("lui_arg2", bus.alu_arg2_out, 32'h12345000);
        offer(7'b0010111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd2, 32'd5, 32'd0, 32'h1000, 32'h100);
        tick();
        chk("auipc_arg1", bus.alu_arg1_out, 32'h100);
        chk("auipc_arg2", bus.alu_arg2_out, 32'h1000);
        chk("auipc_cid", 32'(bus.alu_cid_out), 32'd0);

        // Reset in the middle of a hold
        bus.ex_ready_in = 1'b0;
        offer(7'b1100111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd3, 32'd0, 32'd0, 32'd0, 32'h300);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_hold_ready", 32'(bus.dec_ready_out), 32'd1);
        tick();
        chk("rst_hold_valid", 32'(bus.ex_valid_out), 32'd0);
        chk("rst_hold_arg1", bus.alu_arg1_out, 32'd0);
        chk("rst_hold_rd", 32'(bus.ex_rd_out), 32'd0);
        rst = 1'b0;
        bus.dec_valid_in = 1'b0;
        tick();

        // Plain consume with no new offer
        bus.ex_ready_in = 1'b1;
        offer(7'b0000011, 3'd2, 7'd0, 5'd2, 5'd0, 5'd6, 32'h40, 32'd0, 32'd4, 32'd0);
        tick();
        chk("load_arg1", bus.alu_arg1_out, 32'h40);
        bus.dec_valid_in = 1'b0;
        tick();
        chk("drain_valid", 32'(bus.ex_valid_out), 32'd0);
        tick();
        tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
